// File: rtl/imem_arb_pkg.sv
// Shared types for the instruction-memory arbiter: FSM states and owner encoding.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package imem_arb_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH  = 1'b0,
        OWN_LOADER = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/imem_arb_pick.sv
// Combinational grant picker for the imem arbiter (fetch vs loader).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when a grant is taken (IDLE only).
// Ports: f_req_i/l_req_i requests, last_owner_i previous grant owner,
//        gnt_vld_o any request present, gnt_owner_o chosen owner.
// Build option: IMEM_ARB_RR_EN selects round-robin; otherwise loader has fixed priority.
module imem_arb_pick
    import imem_arb_pkg::*;
(
    input  logic       f_req_i,
    input  logic       l_req_i,
    input  arb_owner_t last_owner_i,
    output logic       gnt_vld_o,
    output arb_owner_t gnt_owner_o
);

    always_comb begin
        gnt_vld_o   = f_req_i | l_req_i;
        gnt_owner_o = OWN_FETCH;
`ifdef IMEM_ARB_RR_EN
        // Contended: hand the memory to whoever did not have it last time.
        if (f_req_i && l_req_i) begin
            gnt_owner_o = (last_owner_i == OWN_FETCH) ? OWN_LOADER : OWN_FETCH;
        end else if (l_req_i) begin
            gnt_owner_o = OWN_LOADER;
        end
`else
        if (l_req_i) begin
            gnt_owner_o = OWN_LOADER;
        end
`endif
    end

`ifndef IMEM_ARB_RR_EN
    // Fixed priority has no use for the history input.
    arb_owner_t unused_last_owner;
    assign unused_last_owner = last_owner_i;
`endif

endmodule

// File: rtl/imem_arbiter.sv
// Serialises fetch and loader accesses onto the single-port instruction BRAM.
// Latency: req seen in IDLE at T -> done + registered data at T+READ_LAT+1.
// Backpressure: requesters hold req/addr/data until their done; the loser just waits.
// Ports: fetch (f_*), loader (l_*), BRAM side (mem_*), busy = FSM not in IDLE.
// Build option: IMEM_ARB_RR_EN enables round-robin and the last-owner register.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int MEM_AW   = 15,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic              f_done,
    output logic [31:0]       f_data,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [31:0]       l_addr,
    input  logic [31:0]       l_wdata,
    output logic              l_done,
    output logic [31:0]       l_rdata,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_t        state_q;
    arb_owner_t        owner_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              acc_we_q;    // current access is a write (persists past the mem_we pulse)
    logic              mem_we_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       f_data_q;
    logic [31:0]       l_rdata_q;
    logic              f_done_q;
    logic              l_done_q;

    arb_owner_t        last_owner;
    logic              gnt_vld;
    arb_owner_t        gnt_owner;
    logic [31:0]       sel_addr;
    logic              sel_we;

    // Only addr[MEM_AW+1:2] reach the memory; upper bits wrap, byte offset ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{f_addr, l_addr};

    imem_arb_pick u_pick (
        .f_req_i      (f_req),
        .l_req_i      (l_req),
        .last_owner_i (last_owner),
        .gnt_vld_o    (gnt_vld),
        .gnt_owner_o  (gnt_owner)
    );

    assign sel_addr = (gnt_owner == OWN_LOADER) ? l_addr : f_addr;
    assign sel_we   = (gnt_owner == OWN_LOADER) && l_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_FETCH;
            cnt_q       <= '0;
            acc_we_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            f_data_q    <= '0;
            l_rdata_q   <= '0;
            f_done_q    <= 1'b0;
            l_done_q    <= 1'b0;
        end else begin
            // Pulses default low; everything else holds unless updated below.
            f_done_q <= 1'b0;
            l_done_q <= 1'b0;
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_vld) begin
                        owner_q    <= gnt_owner;
                        mem_addr_q <= sel_addr[MEM_AW+1:2];
                        acc_we_q   <= sel_we;
                        mem_we_q   <= sel_we;   // single-cycle strobe in first ACCESS cycle
                        if (gnt_owner == OWN_LOADER) begin
                            mem_wdata_q <= l_wdata;
                        end
                        cnt_q   <= CNT_INIT;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        if (owner_q == OWN_LOADER) begin
                            l_done_q <= 1'b1;
                            if (!acc_we_q) begin
                                l_rdata_q <= mem_rdata;
                            end
                        end else begin
                            f_done_q <= 1'b1;
                            f_data_q <= mem_rdata;
                        end
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                RESP: begin
                    // Done is visible this cycle; requests wait for the next IDLE.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef IMEM_ARB_RR_EN
    arb_owner_t last_owner_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_q <= OWN_FETCH;
        end else if (state_q == IDLE && gnt_vld) begin
            last_owner_q <= gnt_owner;
        end
    end

    assign last_owner = last_owner_q;
`else
    assign last_owner = OWN_FETCH;
`endif

    assign f_done    = f_done_q;
    assign f_data    = f_data_q;
    assign l_done    = l_done_q;
    assign l_rdata   = l_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_imem_arbiter.sv
// Testbench for imem_arbiter: BRAM model with 2-cycle read latency and a
// per-requester queue of expected (data, completion cycle) pairs.
// Inputs change 1 time unit after posedge or at negedge; outputs sampled at negedge.
module tb_imem_arbiter;

    localparam int MEM_AW   = 15;
    localparam int READ_LAT = 2;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              f_req;
    logic [31:0]       f_addr;
    logic              f_done;
    logic [31:0]       f_data;
    logic              l_req;
    logic              l_we;
    logic [31:0]       l_addr;
    logic [31:0]       l_wdata;
    logic              l_done;
    logic [31:0]       l_rdata;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              busy;

    // Back-door preload port into the memory model.
    logic              tb_we;
    logic [MEM_AW-1:0] tb_waddr;
    logic [31:0]       tb_wdata;

    logic [31:0] mem [0:(1<<MEM_AW)-1];
    logic [31:0] rd_q;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_f_q[$];
    exp_t exp_l_q[$];
    logic [31:0] l_rdata_model;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Read data appears one edge after the address, so it is only correct
    // once the address has been held for READ_LAT=2 cycles.
    always @(posedge clk) begin
        if (tb_we) mem[tb_waddr] <= tb_wdata;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        rd_q <= mem[mem_addr];
    end
    assign mem_rdata = rd_q;

    imem_arbiter #(.MEM_AW(MEM_AW), .READ_LAT(READ_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_done    (f_done),
        .f_data    (f_data),
        .l_req     (l_req),
        .l_we      (l_we),
        .l_addr    (l_addr),
        .l_wdata   (l_wdata),
        .l_done    (l_done),
        .l_rdata   (l_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit ldr, input int budget, output bit seen, output int at);
        seen = 1'b0;
        at   = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if ((ldr ? l_done : f_done) === 1'b1) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; f_req = 1'b0; f_addr = '0; l_req = 1'b0; l_we = 1'b0;
        l_addr = '0; l_wdata = '0; tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
        tick();
        tb_we = 1'b1;
        tb_waddr = 15'd5; tb_wdata = 32'hDEADBEEF; tick();
        for (int i = 0; i < 6; i++) begin
            tb_waddr = 15'(100 + i); tb_wdata = 32'hA500_0000 + 32'(i); tick();
        end
        tb_we = 1'b0;
        @(negedge clk);
        n_checks++; if (f_done !== 1'b0) begin n_fail++; $display("FAIL reset_f_done: got %b want 0", f_done); end
        n_checks++; if (l_done !== 1'b0) begin n_fail++; $display("FAIL reset_l_done: got %b want 0", l_done); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        n_checks++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %0h want 0", mem_addr); end
        n_checks++; if (mem_wdata !== '0) begin n_fail++; $display("FAIL reset_mem_wdata: got %0h want 0", mem_wdata); end
        n_checks++; if (f_data !== '0) begin n_fail++; $display("FAIL reset_f_data: got %0h want 0", f_data); end
        n_checks++; if (l_rdata !== '0) begin n_fail++; $display("FAIL reset_l_rdata: got %0h want 0", l_rdata); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        l_rdata_model = '0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fetch_read(input logic [31:0] addr, input logic [MEM_AW-1:0] exp_word,
                                   input logic [31:0] exp_data);
        bit   seen;
        int   at;
        int   t0;
        exp_t e;
        tick();
        f_addr = addr; f_req = 1'b1; t0 = cyc;
        exp_f_q.push_back('{data: exp_data, cyc: t0 + READ_LAT + 1});
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fetch_busy_T: got %b want 0", busy); end
        for (int k = 1; k <= READ_LAT; k++) begin
            @(negedge clk);
            n_checks++; if (mem_addr !== exp_word) begin n_fail++; $display("FAIL fetch_addr_T+%0d: got %0h want %0h", k, mem_addr, exp_word); end
            n_checks++; if (f_done !== 1'b0) begin n_fail++; $display("FAIL fetch_early_done_T+%0d: got %b want 0", k, f_done); end
            n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL fetch_mem_we_T+%0d: got %b want 0", k, mem_we); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fetch_busy_T+%0d: got %b want 1", k, busy); end
        end
        wait_done(1'b0, 10, seen, at);
        f_req = 1'b0;
        e = exp_f_q.pop_front();
        n_checks++; if (!seen || at != e.cyc) begin n_fail++; $display("FAIL fetch_done_cycle: got %0d want %0d", at, e.cyc); end
        n_checks++; if (f_data !== e.data) begin n_fail++; $display("FAIL fetch_data: got %h want %h", f_data, e.data); end
        @(negedge clk);
        n_checks++; if (f_done !== 1'b0) begin n_fail++; $display("FAIL fetch_done_width: got %b want 0", f_done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fetch_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_loader_wr_rd();
        bit   seen;
        int   at;
        int   t0;
        int   we_cnt;
        int   done_cnt;
        exp_t e;
        we_cnt = 0; done_cnt = 0;
        tick();
        l_req = 1'b1; l_we = 1'b1; l_addr = 32'h40; l_wdata = 32'h12345678; t0 = cyc;
        exp_l_q.push_back('{data: l_rdata_model, cyc: t0 + 3});
        exp_l_q.push_back('{data: 32'h12345678, cyc: t0 + 7});
        for (int i = 0; i < 16 && done_cnt < 2; i++) begin
            @(negedge clk);
            if (mem_we === 1'b1) begin
                we_cnt++;
                n_checks++; if (mem_addr !== 15'd16 || mem_wdata !== 32'h12345678) begin n_fail++; $display("FAIL ldr_write_port: got addr %0d data %h want 16 12345678", mem_addr, mem_wdata); end
            end
            if (l_done === 1'b1) begin
                done_cnt++;
                e = exp_l_q.pop_front();
                n_checks++; if (cyc != e.cyc) begin n_fail++; $display("FAIL ldr_done_cycle_%0d: got %0d want %0d", done_cnt, cyc, e.cyc); end
                n_checks++; if (l_rdata !== e.data) begin n_fail++; $display("FAIL ldr_rdata_%0d: got %h want %h", done_cnt, l_rdata, e.data); end
                // Keep req high and turn the write into a read of the same word.
                if (done_cnt == 1) l_we = 1'b0;
                else l_req = 1'b0;
            end
        end
        l_req = 1'b0;
        l_rdata_model = 32'h12345678;
        n_checks++; if (we_cnt != 1) begin n_fail++; $display("FAIL ldr_we_pulses: got %0d want 1", we_cnt); end
        n_checks++; if (done_cnt != 2) begin n_fail++; $display("FAIL ldr_done_count: got %0d want 2", done_cnt); end
        exp_l_q.delete();
        seen = 1'b0; at = 0;
    endtask

    task automatic test_both_rise();
        int   t0;
        exp_t e;
        tick();
        f_req = 1'b1; f_addr = 32'h14; l_req = 1'b1; l_we = 1'b0; l_addr = 32'h40; t0 = cyc;
`ifdef IMEM_ARB_RR_EN
        exp_f_q.push_back('{data: 32'hDEADBEEF, cyc: t0 + 3});
        exp_l_q.push_back('{data: l_rdata_model, cyc: t0 + 7});
`else
        exp_l_q.push_back('{data: l_rdata_model, cyc: t0 + 3});
        exp_f_q.push_back('{data: 32'hDEADBEEF, cyc: t0 + 7});
`endif
        for (int i = 0; i < 16 && (exp_f_q.size() + exp_l_q.size()) > 0; i++) begin
            @(negedge clk);
            if (l_done === 1'b1) begin
                l_req = 1'b0;
                if (exp_l_q.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL both_extra_l_done: got pulse at %0d want none", cyc);
                end else begin
                    e = exp_l_q.pop_front();
                    n_checks++; if (cyc != e.cyc) begin n_fail++; $display("FAIL both_l_done_cycle: got %0d want %0d", cyc, e.cyc); end
                    n_checks++; if (l_rdata !== e.data) begin n_fail++; $display("FAIL both_l_rdata: got %h want %h", l_rdata, e.data); end
                end
            end
            if (f_done === 1'b1) begin
                f_req = 1'b0;
                if (exp_f_q.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL both_extra_f_done: got pulse at %0d want none", cyc);
                end else begin
                    e = exp_f_q.pop_front();
                    n_checks++; if (cyc != e.cyc) begin n_fail++; $display("FAIL both_f_done_cycle: got %0d want %0d", cyc, e.cyc); end
                    n_checks++; if (f_data !== e.data) begin n_fail++; $display("FAIL both_f_data: got %h want %h", f_data, e.data); end
                end
            end
        end
        n_checks++; if (exp_f_q.size() + exp_l_q.size() != 0) begin n_fail++; $display("FAIL both_missing_done: got %0d outstanding want 0", exp_f_q.size() + exp_l_q.size()); end
        exp_f_q.delete(); exp_l_q.delete();
        f_req = 1'b0; l_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit   seen;
        int   at;
        int   extra;
        exp_t e;
        tick();
        f_addr = 32'(100) << 2; f_req = 1'b1;
        exp_f_q.push_back('{data: 32'hA500_0000, cyc: cyc + 3});
        for (int k = 0; k < 6; k++) begin
            wait_done(1'b0, 10, seen, at);
            e = exp_f_q.pop_front();
            n_checks++; if (!seen || at != e.cyc) begin n_fail++; $display("FAIL stream_done_cycle_%0d: got %0d want %0d", k, at, e.cyc); end
            n_checks++; if (f_data !== e.data) begin n_fail++; $display("FAIL stream_data_%0d: got %h want %h", k, f_data, e.data); end
            if (k < 5) begin
                f_addr = 32'(101 + k) << 2;
                exp_f_q.push_back('{data: 32'hA500_0000 + 32'(k + 1), cyc: e.cyc + READ_LAT + 2});
            end else begin
                f_req = 1'b0;
            end
        end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (f_done === 1'b1) extra++;
        end
        n_checks++; if (extra != 0) begin n_fail++; $display("FAIL stream_extra_done: got %0d want 0", extra); end
        exp_f_q.delete();
    endtask

    task automatic test_reset_mid();
        int ldone;
        tick();
        l_req = 1'b1; l_we = 1'b1; l_addr = 32'h80; l_wdata = 32'hCAFEF00D;
        tick();
        rst = 1'b1; l_req = 1'b0; l_we = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL rstmid_we_pulse: got %b want 1", mem_we); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_mem_we: got %b want 0", mem_we); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        l_rdata_model = '0;
        ldone = (l_done === 1'b1) ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (l_done === 1'b1) ldone++;
        end
        n_checks++; if (ldone != 0) begin n_fail++; $display("FAIL rstmid_l_done: got %0d pulses want 0", ldone); end
        n_checks++; if (l_rdata !== l_rdata_model) begin n_fail++; $display("FAIL rstmid_l_rdata: got %h want %h", l_rdata, l_rdata_model); end
    endtask

    initial begin
        test_reset();
        test_fetch_read(32'h0000_0014, 15'd5, 32'hDEADBEEF);
        test_loader_wr_rd();
        test_both_rise();
        test_back_to_back();
        test_reset_mid();
        test_fetch_read(32'h0000_0014, 15'd5, 32'hDEADBEEF);
        test_fetch_read(32'h0002_0014, 15'd5, 32'hDEADBEEF);
        test_fetch_read(32'h0002_0197, 15'd101, 32'hA500_0001);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the core's single-port instruction memory between two requesters: the fetch stage (read-only) and the program loader (read/write, used to fill memory over UART and verify it). It sits between fetch/loader and the instruction BRAM. It serialises accesses, hides the BRAM's fixed read latency behind a req/done handshake, and returns read data registered.

## Interface
- `MEM_AW`, default 15: word-address width of the memory.
- `READ_LAT`, default 2: number of cycles the address must be held before `mem_rdata` is valid. Must be ≥1.
- `clk` in 1: clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `f_req` in 1: fetch request (level).
- `f_addr` in 32: fetch byte address.
- `f_done` out 1: one-cycle completion pulse for fetch.
- `f_data` out 32: fetch read data, registered.
- `l_req` in 1: loader request (level).
- `l_we` in 1: loader write enable.
- `l_addr` in 32: loader byte address.
- `l_wdata` in 32: loader write data.
- `l_done` out 1: one-cycle completion pulse for loader.
- `l_rdata` out 32: loader read data, registered.
- `mem_addr` out MEM_AW: word address, equal to `addr[MEM_AW+1:2]`.
- `mem_we` out 1: memory write strobe.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **States**
  - IDLE: evaluate requests.
  - ACCESS: hold the address; `cnt` counts down from READ_LAT-1.
  - RESP: pulse done.
- **IDLE**
  - If either req is high, choose an owner.
  - Latch the owner, `mem_addr`, we (forced 0 for fetch) and wdata.
  - Load `cnt` = READ_LAT-1 and go to ACCESS.
- **Arbitration:** fixed priority, loader over fetch.
- **ACCESS**
  - `mem_we` is high only in the first ACCESS cycle, and only for a loader write.
  - `mem_addr` and `mem_wdata` stay stable throughout.
  - When `cnt`==0, capture `mem_rdata` into the owner's data register, but only for reads, and go to RESP.
  - Otherwise decrement `cnt`.
- **RESP**
  - Assert the owner's done for this one cycle.
  - Requests are ignored in this cycle.
  - Go to IDLE.
- **Writes:** follow the same state sequence. `l_rdata` holds its previous value.
- **Requester rules**
  - A requester holds req, addr, we and wdata stable until it sees its done.
  - It may keep req high after done to issue its next access. That access is seen in the following IDLE cycle.
- **Non-owner requester:** its request waits untouched. It is never dropped, but under fixed priority it can be starved by continuous loader traffic. This is accepted, because the loader runs only while the core is held.
- **Address wrap:** bits above `MEM_AW+1` are ignored, so addresses wrap modulo the memory size. `addr[1:0]` are ignored.
- **Outputs not updated** in a given cycle hold their value.

## Timing
- Request seen in IDLE in cycle T:
  - `mem_addr` is valid in cycles T+1 … T+READ_LAT.
  - `mem_we` pulses in T+1.
  - Data is captured at the end of T+READ_LAT.
  - done and new data are visible in T+READ_LAT+1.
- Latency from req to done is READ_LAT+1 cycles. Peak throughput is one access per READ_LAT+2 cycles.
- Both reqs rising in the same cycle: the loader is granted in T. Fetch is granted at the earliest in T+READ_LAT+2.
- A req that rises while busy is granted in the first IDLE cycle that follows.
- **Reset**
  - State goes to IDLE, `cnt`=0, last-owner=fetch.
  - All outputs are 0: done pulses, `mem_we`, `mem_addr`, `mem_wdata`, `f_data`, `l_rdata`, `busy`.
  - Reset asserted mid-operation abandons the access. No done is issued, and `mem_we` is 0 from the next cycle.

## Configuration
- `IMEM_ARB_RR_EN` defined: round-robin arbitration.
  - When both reqs are high in IDLE, grant the requester that was not the last owner.
  - A single req is granted immediately.
  - Last-owner updates on every grant.
- `IMEM_ARB_RR_EN` undefined: fixed priority, loader over fetch. The last-owner register is not built.

## Structure
- **Shared package `imem_arb_pkg`:**
  - `arb_state_t` enum {IDLE, ACCESS, RESP}.
  - `arb_owner_t` enum {OWN_FETCH, OWN_LOADER}.
- **Sub-module `imem_arb_pick`:** a combinational picker.
  - Inputs: `f_req`, `l_req`, last-owner.
  - Outputs: grant valid, owner.
  - Contains the `IMEM_ARB_RR_EN` choice.
- **Top:** the FSM, counter and datapath registers.

## Test plan
- READ_LAT=2, memory word 5 = 0xDEADBEEF; `f_req` with `f_addr`=0x14 in T.
  - `mem_addr`=5 in T+1..T+2.
  - `f_done` is high only in T+3, with `f_data`=0xDEADBEEF.
- Loader writes 0x12345678 to 0x40, then reads 0x40.
  - `mem_we` pulses once, with `mem_addr`=16.
  - `l_done` fires twice.
  - `l_rdata`=0x12345678 after the read.
- `f_req` and `l_req` both rise in T, fixed priority.
  - `l_done` in T+3, `f_done` in T+7.
  - With `IMEM_ARB_RR_EN`, last-owner=loader, both held: the order alternates fetch, loader, fetch.
- `f_req` held high continuously.
  - `f_done` pulses every 4 cycles.
  - No access is duplicated or skipped.
- `rst` asserted in the cycle after a loader-write grant.
  - `mem_we`=0 from the next cycle, no `l_done`, `busy`=0.
  - A fresh fetch afterwards completes normally.
- `f_addr`=0x0002_0014 with MEM_AW=15.
  - `mem_addr`=5 (wrap), data from word 5.
